// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and line-address helper for the dcache
// memory-bus bridge.
package dcache_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int RV32_ADDR_WIDTH = 32;
  localparam int LINE_BEATS      = 4;
  localparam int LINE_W          = LINE_BEATS * DATA_WIDTH;

  localparam logic [RV32_ADDR_WIDTH-1:0] LINE_OFFSET_MASK = 32'h0000_000F;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DRAIN
  } state_e;

  function automatic logic [RV32_ADDR_WIDTH-1:0] line_base(
    input logic [RV32_ADDR_WIDTH-1:0] addr
  );
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/dcache_wb_buf.sv
// Single-entry write-back buffer: holds one dirty victim line and its base
// address, and serves one 32-bit word per beat.
module dcache_wb_buf
  import dcache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_en,
  input  logic [RV32_ADDR_WIDTH-1:0] cap_addr,
  input  logic [LINE_W-1:0]          cap_data,
  input  logic                       clr,
  input  logic [1:0]                 beat_sel,
  output logic                       valid,
  output logic [RV32_ADDR_WIDTH-1:0] base,
  output logic [DATA_WIDTH-1:0]      word
);

  logic [LINE_W-1:0] line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (cap_en) begin
      valid <= 1'b1;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      base <= line_base(cap_addr);
      line <= cap_data;
    end
  end

  assign word = line[{beat_sel, 5'd0} +: DATA_WIDTH];

endmodule

// File: rtl/dcache_ram_if.sv
// Bridges dcache line refills and dirty write-backs onto a single-beat
// request/grant memory bus; write-backs always drain before a refill is taken.
module dcache_ram_if
  import dcache_pkg::*;
#(
  parameter int LINE_BEATS = dcache_pkg::LINE_BEATS,
  parameter int MEM_ADDR_W = dcache_pkg::RV32_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ram_rd_req_i,
  input  logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_i,
  output logic                       ram_rd_rdy_o,
  output logic [DATA_WIDTH-1:0]      ram_rd_data_o,
  output logic [2:0]                 ram_rd_num_o,
  output logic                       ram_wr_rdy_o,
  input  logic                       ram_wr_req_i,
  input  logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_i,
  input  logic [LINE_W-1:0]          ram_wr_data_i,
  input  logic                       ram_dirty_i,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [MEM_ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);
  localparam logic [2:0] LAST_RET  = 3'(LINE_BEATS - 1);

  state_e                       state, state_nxt;
  logic [1:0]                   beat_cnt;
  logic [2:0]                   ret_cnt;
  logic [RV32_ADDR_WIDTH-1:0]   rd_base;
  logic                         buf_valid, buf_clr, wr_cap;
  logic [RV32_ADDR_WIDTH-1:0]   wb_base;
  logic [DATA_WIDTH-1:0]        wb_word;
  logic                         rd_acc, rd_ret;

  // Clean victims are consumed here without ever touching the buffer.
  assign wr_cap       = ram_wr_req_i & ram_dirty_i & ~buf_valid;
  assign ram_wr_rdy_o = ~buf_valid;
  assign rd_ret       = mem_rvalid_i & ((state == RD_ISSUE) | (state == RD_DRAIN));
  assign ram_rd_rdy_o = rd_acc & ~rst;

  dcache_wb_buf u_wb_buf (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (wr_cap),
    .cap_addr (ram_wr_addr_i),
    .cap_data (ram_wr_data_i),
    .clr      (buf_clr),
    .beat_sel (beat_cnt),
    .valid    (buf_valid),
    .base     (wb_base),
    .word     (wb_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_acc      = 1'b0;
    buf_clr     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        // A pending or just-arriving write-back wins so a refill never reads stale memory.
        if (buf_valid || wr_cap) begin
          state_nxt = WR;
        end else if (ram_rd_req_i) begin
          rd_acc    = 1'b1;
          state_nxt = RD_ISSUE;
        end
      end
      WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = MEM_ADDR_W'(wb_base | 32'({beat_cnt, 2'b00}));
        mem_wdata_o = wb_word;
        if (mem_gnt_i && beat_cnt == LAST_BEAT) begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = MEM_ADDR_W'(rd_base | 32'({beat_cnt, 2'b00}));
        if (mem_gnt_i && beat_cnt == LAST_BEAT) begin
          state_nxt = (rd_ret && ret_cnt == LAST_RET) ? IDLE : RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (rd_ret && ret_cnt == LAST_RET) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter wraps back to 0 after the last grant of every transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt      <= '0;
      ret_cnt       <= '0;
      ram_rd_num_o  <= '0;
      ram_rd_data_o <= '0;
    end else begin
      if (mem_req_o && mem_gnt_i) begin
        beat_cnt <= beat_cnt + 2'd1;
      end
      if (rd_acc) begin
        ret_cnt <= '0;
      end else if (rd_ret) begin
        ret_cnt <= ret_cnt + 3'd1;
      end
      ram_rd_num_o  <= rd_ret ? (ret_cnt + 3'd1) : 3'd0;
      ram_rd_data_o <= rd_ret ? mem_rdata_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_base <= line_base(ram_rd_addr_i);
    end
  end

endmodule

// File: tb/tb_dcache_ram_if.sv
// Directed bench for dcache_ram_if: a memory model with fixed 2-cycle read
// latency, a negedge bus monitor, and one task per scenario.
module tb_dcache_ram_if;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_rd_req_i;
  logic [31:0]   ram_rd_addr_i;
  logic          ram_rd_rdy_o;
  logic [31:0]   ram_rd_data_o;
  logic [2:0]    ram_rd_num_o;
  logic          ram_wr_rdy_o;
  logic          ram_wr_req_i;
  logic [31:0]   ram_wr_addr_i;
  logic [127:0]  ram_wr_data_i;
  logic          ram_dirty_i;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;

  logic          gnt_en;
  logic          extra_rv;
  logic [31:0]   extra_data;
  logic [31:0]   rd_words [4];
  logic          v1, v2;
  logic [31:0]   d1, d2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_cnt = 0;
  logic [31:0] b_addr [$];
  logic [31:0] b_data [$];
  logic        b_we   [$];
  logic [2:0]  r_num  [$];
  logic [31:0] r_data [$];
  int          r_cyc  [$];

  always #5 clk = ~clk;

  dcache_ram_if dut (
    .clk           (clk),
    .rst           (rst),
    .ram_rd_req_i  (ram_rd_req_i),
    .ram_rd_addr_i (ram_rd_addr_i),
    .ram_rd_rdy_o  (ram_rd_rdy_o),
    .ram_rd_data_o (ram_rd_data_o),
    .ram_rd_num_o  (ram_rd_num_o),
    .ram_wr_rdy_o  (ram_wr_rdy_o),
    .ram_wr_req_i  (ram_wr_req_i),
    .ram_wr_addr_i (ram_wr_addr_i),
    .ram_wr_data_i (ram_wr_data_i),
    .ram_dirty_i   (ram_dirty_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  assign mem_gnt_i    = mem_req_o & gnt_en;
  assign mem_rvalid_i = v2 | extra_rv;
  assign mem_rdata_i  = extra_rv ? extra_data : d2;

  // Memory: read data returns two cycles after the grant cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= mem_req_o & mem_gnt_i & ~mem_we_o;
      d1 <= rd_words[mem_addr_o[3:2]];
      v2 <= v1;
      d2 <= d1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (mem_req_o && mem_gnt_i) begin
      b_addr.push_back(mem_addr_o);
      b_data.push_back(mem_wdata_o);
      b_we.push_back(mem_we_o);
    end
    if (ram_rd_num_o != 3'd0) begin
      r_num.push_back(ram_rd_num_o);
      r_data.push_back(ram_rd_data_o);
      r_cyc.push_back(cyc);
    end
    if (ram_rd_rdy_o) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [31:0] addr, input string nm);
    int b0, r0, k0;
    logic got;
    logic [31:0] base;
    b0 = b_addr.size(); r0 = r_num.size(); k0 = rdy_cnt;
    base = addr & 32'hFFFF_FFF0;
    gnt_en = 1'b1;
    ram_rd_req_i = 1'b1;
    ram_rd_addr_i = addr;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ram_rd_rdy_o) got = 1'b1;
    end
    @(posedge clk); #1;
    ram_rd_req_i = 1'b0;
    for (int i = 0; i < 60 && r_num.size() < r0 + 4; i++) tick();
    repeat (5) tick();
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL %s accept: got=%0b want=1", nm, got); end
    total++;
    if (rdy_cnt - k0 !== 1) begin bad++; $display("FAIL %s rdy_pulses: got=%0d want=1", nm, rdy_cnt - k0); end
    total++;
    if (b_addr.size() - b0 !== 4) begin bad++; $display("FAIL %s beat_count: got=%0d want=4", nm, b_addr.size() - b0); end
    total++;
    if (r_num.size() - r0 !== 4) begin bad++; $display("FAIL %s ret_count: got=%0d want=4", nm, r_num.size() - r0); end
    if (b_addr.size() - b0 == 4 && r_num.size() - r0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (b_addr[b0+k] !== base + 32'(4*k) || b_we[b0+k] !== 1'b0) begin
          bad++; $display("FAIL %s rd_addr%0d: got=%h we=%0b want=%h we=0", nm, k, b_addr[b0+k], b_we[b0+k], base + 32'(4*k));
        end
        total++;
        if (r_num[r0+k] !== 3'(k+1) || r_data[r0+k] !== rd_words[k]) begin
          bad++; $display("FAIL %s ret%0d: got num=%0d data=%h want num=%0d data=%h", nm, k, r_num[r0+k], r_data[r0+k], k+1, rd_words[k]);
        end
        if (k > 0) begin
          total++;
          if (r_cyc[r0+k] - r_cyc[r0+k-1] !== 1) begin
            bad++; $display("FAIL %s b2b%0d: gap=%0d want=1", nm, k, r_cyc[r0+k] - r_cyc[r0+k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt_en = 1'b1; extra_rv = 1'b0; extra_data = '0;
    ram_rd_req_i = 1'b0; ram_rd_addr_i = '0; ram_wr_req_i = 1'b0;
    ram_wr_addr_i = '0; ram_wr_data_i = '0; ram_dirty_i = 1'b0;
    for (int i = 0; i < 4; i++) rd_words[i] = '0;
    tick(); tick();
    total++;
    if ({mem_req_o, mem_we_o, ram_rd_rdy_o, ram_rd_num_o} !== 6'd0) begin
      bad++; $display("FAIL reset_ctrl: got req=%0b we=%0b rdy=%0b num=%0d want 0", mem_req_o, mem_we_o, ram_rd_rdy_o, ram_rd_num_o);
    end
    total++;
    if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0 || ram_rd_data_o !== 32'd0) begin
      bad++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", mem_addr_o, mem_wdata_o, ram_rd_data_o);
    end
    total++;
    if (ram_wr_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_wr_rdy: got=%0b want=1", ram_wr_rdy_o); end
    rst = 1'b0;
    tick();
    total++;
    if (mem_req_o !== 1'b0 || ram_wr_rdy_o !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle: got req=%0b wr_rdy=%0b want 0/1", mem_req_o, ram_wr_rdy_o);
    end
  endtask

  task automatic test_refill();
    rd_words[0] = 32'h0; rd_words[1] = 32'h0; rd_words[2] = 32'hffee_ddcc; rd_words[3] = 32'h0;
    do_refill(32'h0101_0018, "refill");
  endtask

  task automatic test_writeback();
    logic [31:0] exp_w [4];
    int b0;
    exp_w[0] = 32'h1234_5678; exp_w[1] = 32'haabb_ccdd; exp_w[2] = 32'h0066_0000; exp_w[3] = 32'h4433_2211;
    b0 = b_addr.size();
    gnt_en = 1'b1;
    ram_wr_req_i = 1'b1; ram_dirty_i = 1'b1;
    ram_wr_addr_i = 32'h1101_0010;
    ram_wr_data_i = 128'h44332211_00660000_aabbccdd_12345678;
    tick();
    ram_wr_req_i = 1'b0; ram_dirty_i = 1'b0;
    total++;
    if (ram_wr_rdy_o !== 1'b0) begin bad++; $display("FAIL wb_full: got wr_rdy=%0b want=0", ram_wr_rdy_o); end
    tick();
    gnt_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h1101_0014 || mem_wdata_o !== exp_w[1]) begin
        bad++; $display("FAIL wb_stall%0d: got req=%0b we=%0b addr=%h wdata=%h want 1/1/11010014/%h", s, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, exp_w[1]);
      end
      tick();
    end
    total++;
    if (b_addr.size() - b0 !== 1) begin bad++; $display("FAIL wb_stall_grants: got=%0d want=1", b_addr.size() - b0); end
    gnt_en = 1'b1;
    for (int i = 0; i < 20 && b_addr.size() < b0 + 4; i++) tick();
    tick();
    total++;
    if (b_addr.size() - b0 !== 4) begin bad++; $display("FAIL wb_beats: got=%0d want=4", b_addr.size() - b0); end
    if (b_addr.size() - b0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (b_addr[b0+k] !== 32'h1101_0010 + 32'(4*k) || b_data[b0+k] !== exp_w[k] || b_we[b0+k] !== 1'b1) begin
          bad++; $display("FAIL wb_beat%0d: got addr=%h data=%h we=%0b want %h/%h/1", k, b_addr[b0+k], b_data[b0+k], b_we[b0+k], 32'h1101_0010 + 32'(4*k), exp_w[k]);
        end
      end
    end
    total++;
    if (ram_wr_rdy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL wb_done: got wr_rdy=%0b req=%0b want 1/0", ram_wr_rdy_o, mem_req_o);
    end
  endtask

  task automatic test_wr_rd_simul();
    int b0, r0, k0, nb_at;
    logic got;
    b0 = b_addr.size(); r0 = r_num.size(); k0 = rdy_cnt; nb_at = -1;
    rd_words[0] = 32'h1111_1111; rd_words[1] = 32'h2222_2222; rd_words[2] = 32'h3333_3333; rd_words[3] = 32'h4444_4444;
    gnt_en = 1'b1;
    ram_wr_req_i = 1'b1; ram_dirty_i = 1'b1; ram_wr_addr_i = 32'h2000_0004;
    ram_wr_data_i = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h3000_0008;
    #1;
    total++;
    if (ram_rd_rdy_o !== 1'b0) begin bad++; $display("FAIL simul_rd_blocked: got rdy=%0b want=0", ram_rd_rdy_o); end
    tick();
    ram_wr_req_i = 1'b0; ram_dirty_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ram_rd_rdy_o) begin got = 1'b1; nb_at = b_addr.size() - b0; end
      else tick();
    end
    tick();
    ram_rd_req_i = 1'b0;
    for (int i = 0; i < 60 && r_num.size() < r0 + 4; i++) tick();
    total++;
    if (got !== 1'b1 || nb_at !== 4) begin bad++; $display("FAIL simul_rdy_after_wb: got accepted=%0b beats_before=%0d want 1/4", got, nb_at); end
    total++;
    if (rdy_cnt - k0 !== 1) begin bad++; $display("FAIL simul_rdy_pulses: got=%0d want=1", rdy_cnt - k0); end
    total++;
    if (b_addr.size() - b0 !== 8 || r_num.size() - r0 !== 4) begin
      bad++; $display("FAIL simul_counts: got beats=%0d rets=%0d want 8/4", b_addr.size() - b0, r_num.size() - r0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (b_we[b0+k] !== 1'b1 || b_addr[b0+k] !== 32'h2000_0000 + 32'(4*k) || b_data[b0+k] !== {4{8'haa + 8'(17*k)}}) begin
          bad++; $display("FAIL simul_wr%0d: got we=%0b addr=%h data=%h", k, b_we[b0+k], b_addr[b0+k], b_data[b0+k]);
        end
        total++;
        if (b_we[b0+4+k] !== 1'b0 || b_addr[b0+4+k] !== 32'h3000_0000 + 32'(4*k)) begin
          bad++; $display("FAIL simul_rd%0d: got we=%0b addr=%h want 0/%h", k, b_we[b0+4+k], b_addr[b0+4+k], 32'h3000_0000 + 32'(4*k));
        end
        total++;
        if (r_num[r0+k] !== 3'(k+1) || r_data[r0+k] !== rd_words[k]) begin
          bad++; $display("FAIL simul_ret%0d: got num=%0d data=%h want %0d/%h", k, r_num[r0+k], r_data[r0+k], k+1, rd_words[k]);
        end
      end
    end
  endtask

  task automatic test_clean_write();
    int b0, r0;
    b0 = b_addr.size(); r0 = r_num.size();
    ram_wr_req_i = 1'b1; ram_dirty_i = 1'b0; ram_wr_addr_i = 32'h5000_0000;
    ram_wr_data_i = 128'h01234567_89abcdef_fedcba98_76543210;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++;
      if (mem_req_o !== 1'b0 || ram_wr_rdy_o !== 1'b1) begin
        bad++; $display("FAIL clean_wr%0d: got req=%0b wr_rdy=%0b want 0/1", s, mem_req_o, ram_wr_rdy_o);
      end
    end
    ram_wr_req_i = 1'b0;
    extra_rv = 1'b1; extra_data = 32'hdead_beef;
    tick();
    extra_rv = 1'b0;
    total++;
    if (ram_rd_num_o !== 3'd0 || ram_rd_data_o !== 32'd0) begin
      bad++; $display("FAIL stray_rvalid: got num=%0d data=%h want 0/0", ram_rd_num_o, ram_rd_data_o);
    end
    tick();
    total++;
    if (b_addr.size() !== b0 || r_num.size() !== r0) begin
      bad++; $display("FAIL clean_traffic: got beats=%0d rets=%0d want 0/0", b_addr.size() - b0, r_num.size() - r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0, bsz;
    r0 = r_num.size();
    rd_words[0] = 32'ha1a1_a1a1; rd_words[1] = 32'ha2a2_a2a2; rd_words[2] = 32'ha3a3_a3a3; rd_words[3] = 32'ha4a4_a4a4;
    gnt_en = 1'b1;
    ram_rd_req_i = 1'b1; ram_rd_addr_i = 32'h4000_0020;
    tick();
    ram_rd_req_i = 1'b0;
    for (int i = 0; i < 40 && r_num.size() < r0 + 2; i++) tick();
    rst = 1'b1;
    bsz = b_addr.size();
    #1;
    total++;
    if (ram_rd_num_o !== 3'd0 || ram_rd_data_o !== 32'd0 || mem_req_o !== 1'b0 || ram_rd_rdy_o !== 1'b0 || ram_wr_rdy_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_outputs: got num=%0d data=%h req=%0b rdy=%0b wr_rdy=%0b", ram_rd_num_o, ram_rd_data_o, mem_req_o, ram_rd_rdy_o, ram_wr_rdy_o);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    total++;
    if (r_num.size() - r0 !== 2 || b_addr.size() !== bsz) begin
      bad++; $display("FAIL rst_mid_quiet: got rets=%0d new_beats=%0d want 2/0", r_num.size() - r0, b_addr.size() - bsz);
    end
    do_refill(32'h4000_003c, "refill_after_rst");
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_wr_rd_simul();
    test_clean_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
